// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM frequency generator: select width and the
// select-to-step-divider mapping.
package pwm_pkg;

  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

  // Clocks per PWM step for a given select; each select step below SEL_MAX doubles it.
  function automatic int unsigned div_of(input int unsigned base,
                                         input logic [SEL_W-1:0] sel);
    return base << (SEL_MAX - sel);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Step prescaler: counts clocks up to div-1 and flags the step tick.
module pwm_prescaler #(
  parameter int unsigned PW = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [PW:0] div,
  input  logic        clr,
  output logic        tick_c
);

  localparam int unsigned DIV_W = PW + 1;

  logic [PW-1:0] presc_cnt;

  assign tick_c = ({1'b0, presc_cnt} == (div - DIV_W'(1)));

  always_ff @(posedge clock) begin
    if (reset || clr || tick_c) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_freq_gen.sv
// PWM carrier generator: period scales by powers of two with the frequency
// select; select and duty are shadowed and only reload at a period boundary.
module pwm_freq_gen
  import pwm_pkg::*;
#(
  parameter int unsigned BASE_DIV = 4,
  parameter int unsigned DUTY_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SEL_W-1:0]  frec_in,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out,
  output logic              period_start,
  output logic [SEL_W-1:0]  sel_active
);

  localparam int unsigned PWM_STEPS = 2 ** DUTY_W;
  localparam int unsigned PW        = $clog2(BASE_DIV * 128);
  localparam int unsigned DIV_W     = PW + 1;

  logic [DUTY_W-1:0] step_cnt;
  logic [DUTY_W-1:0] duty_l;
  logic [SEL_W-1:0]  sel_l;
  logic              start_pend;
  logic [PW:0]       div;
  logic              tick_c;
  logic              boundary_c;

  assign div        = DIV_W'(div_of(BASE_DIV, sel_l));
  assign boundary_c = start_pend | (tick_c & (step_cnt == DUTY_W'(PWM_STEPS - 1)));
  assign sel_active = sel_l;

  pwm_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .div    (div),
    .clr    (boundary_c),
    .tick_c (tick_c)
  );

  // Step counter, shadow registers and registered compare output.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_cnt     <= '0;
      sel_l        <= '0;
      duty_l       <= '0;
      start_pend   <= 1'b1;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (boundary_c) begin
        sel_l      <= frec_in;
        duty_l     <= duty;
        step_cnt   <= '0;
        start_pend <= 1'b0;
      end else if (tick_c) begin
        step_cnt <= step_cnt + DUTY_W'(1);
      end
      period_start <= boundary_c;
      pwm_out      <= ~start_pend & (step_cnt < duty_l);
    end
  end

endmodule

// File: tb/tb_pwm_freq_gen.sv
// Scoreboard bench for pwm_freq_gen: a period-level reference model queues the
// expected outputs for each clock and an independent monitor checks them.
module tb_pwm_freq_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] frec_in = 3'd7;
  logic [3:0] duty = 4'd4;
  logic       pwm_out;
  logic       period_start;
  logic [2:0] sel_active;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       pwm;
    logic       ps;
    logic [2:0] sel;
  } exp_t;

  exp_t exp_q[$];

  pwm_freq_gen #(
    .BASE_DIV (4),
    .DUTY_W   (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .frec_in      (frec_in),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .sel_active   (sel_active)
  );

  always #5 clock = ~clock;

  // Reference model: tracks the current period as (length, high time) in clocks
  // and the number of clocks elapsed since its first edge.
  bit         m_pend = 1'b1;
  int         m_pos = 0;
  int         m_len = 64;
  int         m_high = 0;
  logic [2:0] m_sel = 3'd0;

  always @(posedge clock) begin : model
    exp_t e;
    bit   bnd;
    int   dv;
    if (reset) begin
      m_pend = 1'b1;
      m_pos  = 0;
      m_high = 0;
      m_sel  = 3'd0;
      e.pwm  = 1'b0;
      e.ps   = 1'b0;
      e.sel  = 3'd0;
    end else begin
      bnd   = m_pend || (m_pos + 1 == m_len);
      e.pwm = !m_pend && (m_pos + 1 <= m_high);
      e.ps  = bnd;
      if (bnd) begin
        dv     = 4 << (7 - int'(frec_in));
        m_sel  = frec_in;
        m_len  = 16 * dv;
        m_high = int'(duty) * dv;
        m_pos  = 0;
        m_pend = 1'b0;
      end else begin
        m_pos = m_pos + 1;
      end
      e.sel = m_sel;
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every clock the DUT presents a new output sample.
  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected >=1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
      chk("period_start", 32'(period_start), 32'(e.ps));
      chk("sel_active", 32'(sel_active), 32'(e.sel));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    // Reset for 3 clocks at sel 7, duty 4, then several periods.
    reset   = 1'b1;
    frec_in = 3'd7;
    duty    = 4'd4;
    cyc(3);
    reset = 1'b0;
    cyc(200);

    // Select change mid-period: takes effect at the next boundary.
    frec_in = 3'd6;
    cyc(400);

    // Duty extremes at sel 7.
    frec_in = 3'd7;
    duty    = 4'd0;
    cyc(200);
    duty = 4'd15;
    cyc(200);

    // Single-clock reset in the middle of a period.
    duty = 4'd8;
    cyc(70);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(150);

    // Duty toggling every clock.
    frec_in = 3'd7;
    repeat (300) begin
      duty = 4'($urandom);
      cyc(1);
    end

    // Random select/duty changes with occasional resets.
    repeat (60) begin
      frec_in = 3'($urandom_range(4, 7));
      duty    = 4'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        cyc($urandom_range(1, 3));
        reset = 1'b0;
      end
      cyc($urandom_range(1, 200));
    end

    // Slowest setting: 8192-clock periods at 50% duty.
    frec_in = 3'd0;
    duty    = 4'd8;
    cyc(3 * 8192);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
